// File: rtl/fm_guard_pack_writer_if.sv
// Stream, control and word-write signals of the FM/guard pack writer.
// The writer connects through the slave modport; the feeding stage and the buffers use master.
interface fm_guard_pack_writer_if #(
  parameter int FM_WORD_BYTES   = 8,
  parameter int GUARDS_PER_WORD = 4,
  parameter int FM_AW           = 10,
  parameter int GD_AW           = 8
);
  logic                           ctrl_valid;
  logic                           ctrl_ready;
  logic [FM_AW-1:0]               fm_base_i;
  logic [GD_AW-1:0]               gd_base_i;
  logic                           flush_i;
  logic                           done_o;
  logic [7:0]                     data_i;
  logic                           data_i_valid;
  logic                           fm_buf_ready;
  logic [5:0]                     guard_i;
  logic                           guard_i_valid;
  logic                           guard_buf_ready;
  logic                           fm_wr_en;
  logic                           fm_wr_gnt;
  logic [FM_AW-1:0]               fm_wr_addr;
  logic [8*FM_WORD_BYTES-1:0]     fm_wr_data;
  logic [FM_WORD_BYTES-1:0]       fm_wr_mask;
  logic                           gd_wr_en;
  logic                           gd_wr_gnt;
  logic [GD_AW-1:0]               gd_wr_addr;
  logic [6*GUARDS_PER_WORD-1:0]   gd_wr_data;
  logic [GUARDS_PER_WORD-1:0]     gd_wr_mask;
  logic [FM_AW:0]                 fm_word_cnt_o;
  logic [GD_AW:0]                 gd_word_cnt_o;

  modport master (
    output ctrl_valid, fm_base_i, gd_base_i, flush_i, data_i, data_i_valid,
           guard_i, guard_i_valid, fm_wr_gnt, gd_wr_gnt,
    input  ctrl_ready, done_o, fm_buf_ready, guard_buf_ready,
           fm_wr_en, fm_wr_addr, fm_wr_data, fm_wr_mask,
           gd_wr_en, gd_wr_addr, gd_wr_data, gd_wr_mask,
           fm_word_cnt_o, gd_word_cnt_o
  );

  modport slave (
    input  ctrl_valid, fm_base_i, gd_base_i, flush_i, data_i, data_i_valid,
           guard_i, guard_i_valid, fm_wr_gnt, gd_wr_gnt,
    output ctrl_ready, done_o, fm_buf_ready, guard_buf_ready,
           fm_wr_en, fm_wr_addr, fm_wr_data, fm_wr_mask,
           gd_wr_en, gd_wr_addr, gd_wr_data, gd_wr_mask,
           fm_word_cnt_o, gd_word_cnt_o
  );
endinterface

// File: rtl/fm_guard_pack_writer.sv
// Packs the FM byte stream and the guard stream into SRAM words and writes them with
// request/grant handshakes; on flush the partial words are written with lane masks.

// One packing side: entry lanes, one pending word register, and a word counter.
module fm_guard_pack_lane #(
  parameter int EW = 8,
  parameter int N  = 8,
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            run,
  input  logic            flushing,
  input  logic [AW-1:0]   base_i,
  input  logic [EW-1:0]   in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            wr_en,
  input  logic            wr_gnt,
  output logic [AW-1:0]   wr_addr,
  output logic [EW*N-1:0] wr_data,
  output logic [N-1:0]    wr_mask,
  output logic [AW:0]     word_cnt,
  output logic            drained
);
  localparam int LW = $clog2(N);

  logic [EW*N-1:0] lanes_q, merged;
  logic [LW-1:0]   lane_q;
  logic [AW-1:0]   base_q;
  logic            pend_q;
  logic [N-1:0]    part_mask;
  logic            acc, last, flush_load;

  assign in_ready   = run && (!pend_q || wr_gnt);
  assign acc        = in_valid && in_ready;
  assign last       = (lane_q == LW'(N-1));
  assign flush_load = flushing && !pend_q && (lane_q != '0);
  assign wr_en      = pend_q;
  assign wr_addr    = base_q + word_cnt[AW-1:0];
  assign drained    = !pend_q && (lane_q == '0);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    merged    = lanes_q;
    merged[lane_q*EW +: EW] = in_data;
    part_mask = '0;
    for (int i = 0; i < N; i++) part_mask[i] = (LW'(i) < lane_q);
  end

  // Lanes are cleared whenever a word leaves them, so a partial word carries zeros above its fill.
  // NOTE: state registers use non-blocking assignments; later statements deliberately override earlier ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_q  <= '0;
      lane_q   <= '0;
      base_q   <= '0;
      pend_q   <= 1'b0;
      wr_data  <= '0;
      wr_mask  <= '0;
      word_cnt <= '0;
    end else if (start) begin
      lanes_q  <= '0;
      lane_q   <= '0;
      base_q   <= base_i;
      pend_q   <= 1'b0;
      word_cnt <= '0;
    end else begin
      if (pend_q && wr_gnt) begin
        pend_q   <= 1'b0;
        word_cnt <= word_cnt + 1'b1;
      end
      if (acc) begin
        lanes_q <= merged;
        lane_q  <= last ? '0 : lane_q + 1'b1;
        if (last) begin
          pend_q  <= 1'b1;
          wr_data <= merged;
          wr_mask <= '1;
          lanes_q <= '0;
        end
      end else if (flush_load) begin
        pend_q  <= 1'b1;
        wr_data <= lanes_q;
        wr_mask <= part_mask;
        lanes_q <= '0;
        lane_q  <= '0;
      end
    end
  end
endmodule

module fm_guard_pack_writer #(
  parameter int FM_WORD_BYTES   = 8,
  parameter int GUARDS_PER_WORD = 4,
  parameter int FM_AW           = 10,
  parameter int GD_AW           = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  fm_guard_pack_writer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t state_q, state_d;
  logic   start, fm_drained, gd_drained;

  assign start          = (state_q == IDLE) && bus.ctrl_valid;
  assign bus.ctrl_ready = (state_q == IDLE);
  assign bus.done_o     = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.ctrl_valid) state_d = RUN;
      RUN:     if (bus.flush_i) state_d = FLUSH;
      FLUSH:   if (fm_drained && gd_drained) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  fm_guard_pack_lane #(.EW(8), .N(FM_WORD_BYTES), .AW(FM_AW)) u_fm (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .run      (state_q == RUN),
    .flushing (state_q == FLUSH),
    .base_i   (bus.fm_base_i),
    .in_data  (bus.data_i),
    .in_valid (bus.data_i_valid),
    .in_ready (bus.fm_buf_ready),
    .wr_en    (bus.fm_wr_en),
    .wr_gnt   (bus.fm_wr_gnt),
    .wr_addr  (bus.fm_wr_addr),
    .wr_data  (bus.fm_wr_data),
    .wr_mask  (bus.fm_wr_mask),
    .word_cnt (bus.fm_word_cnt_o),
    .drained  (fm_drained)
  );

  fm_guard_pack_lane #(.EW(6), .N(GUARDS_PER_WORD), .AW(GD_AW)) u_gd (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .run      (state_q == RUN),
    .flushing (state_q == FLUSH),
    .base_i   (bus.gd_base_i),
    .in_data  (bus.guard_i),
    .in_valid (bus.guard_i_valid),
    .in_ready (bus.guard_buf_ready),
    .wr_en    (bus.gd_wr_en),
    .wr_gnt   (bus.gd_wr_gnt),
    .wr_addr  (bus.gd_wr_addr),
    .wr_data  (bus.gd_wr_data),
    .wr_mask  (bus.gd_wr_mask),
    .word_cnt (bus.gd_word_cnt_o),
    .drained  (gd_drained)
  );
endmodule

// File: tb/tb_fm_guard_pack_writer.sv
// Directed bench for fm_guard_pack_writer: a job table with hand-computed results plus
// hand-written sequences for back-pressure, flush timing and mid-job reset.
module tb_fm_guard_pack_writer;
  localparam int FWB = 8, GPW = 4, FM_AW = 10, GD_AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fm_guard_pack_writer_if #(.FM_WORD_BYTES(FWB), .GUARDS_PER_WORD(GPW), .FM_AW(FM_AW), .GD_AW(GD_AW)) pw ();

  fm_guard_pack_writer #(.FM_WORD_BYTES(FWB), .GUARDS_PER_WORD(GPW), .FM_AW(FM_AW), .GD_AW(GD_AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (pw.slave)
  );

  typedef struct {
    logic [63:0] data;
    logic [15:0] addr;
    logic [15:0] mask;
  } wr_t;

  typedef struct {
    int fm_base; int gd_base; int nb; int ng;
    int fm_words; int fm_last_addr; int fm_last_mask;
    int gd_words; int gd_last_addr; int gd_last_mask;
  } vec_t;

  wr_t  fm_log[$];
  wr_t  gd_log[$];
  vec_t vecs[5];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Granted writes are logged on the falling edge, where inputs and outputs are settled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pw.fm_wr_en && pw.fm_wr_gnt)
        fm_log.push_back('{data: 64'(pw.fm_wr_data), addr: 16'(pw.fm_wr_addr), mask: 16'(pw.fm_wr_mask)});
      if (pw.gd_wr_en && pw.gd_wr_gnt)
        gd_log.push_back('{data: 64'(pw.gd_wr_data), addr: 16'(pw.gd_wr_addr), mask: 16'(pw.gd_wr_mask)});
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int fb, input int gb);
    fm_log.delete();
    gd_log.delete();
    pw.fm_base_i  = FM_AW'(fb);
    pw.gd_base_i  = GD_AW'(gb);
    pw.ctrl_valid = 1'b1;
    @(negedge clk);
    check("ctrl_ready before start", 64'(pw.ctrl_ready), 64'd1);
    tick();
    pw.ctrl_valid = 1'b0;
  endtask

  // Streams nb bytes and ng guards; values count up from the given first values.
  task automatic feed(input int nb, input int ng, input int fm_first, input int gd_first);
    int bi = 0, gi = 0, cyc = 0;
    while ((bi < nb || gi < ng) && cyc < 400) begin
      pw.data_i_valid  = (bi < nb);
      pw.data_i        = 8'(fm_first + bi);
      pw.guard_i_valid = (gi < ng);
      pw.guard_i       = 6'(gd_first + gi);
      @(negedge clk);
      if (pw.data_i_valid && pw.fm_buf_ready) bi++;
      if (pw.guard_i_valid && pw.guard_buf_ready) gi++;
      tick();
      cyc++;
    end
    pw.data_i_valid  = 1'b0;
    pw.guard_i_valid = 1'b0;
    check("bytes accepted", 64'(bi), 64'(nb));
    check("guards accepted", 64'(gi), 64'(ng));
  endtask

  task automatic wait_done();
    int w = 0;
    logic got = 1'b0;
    while (w < 60) begin
      @(negedge clk);
      if (pw.done_o) begin
        got = 1'b1;
        break;
      end
      tick();
      w++;
    end
    check("done_o seen", 64'(got), 64'd1);
    tick();
    check("done_o one cycle", 64'(pw.done_o), 64'd0);
    check("ctrl_ready after done", 64'(pw.ctrl_ready), 64'd1);
  endtask

  task automatic finish_job();
    pw.flush_i = 1'b1;
    tick();
    pw.flush_i = 1'b0;
    wait_done();
  endtask

  // Entry k of a job carries value k+1; word w holds entries w*per .. w*per+per-1.
  task automatic verify_side(input string tag, input wr_t log[$], input int base, input int n,
                             input int per, input int ew, input int aw);
    int nw = (n + per - 1) / per;
    check({tag, " words logged"}, 64'(log.size()), 64'(nw));
    for (int w = 0; w < nw && w < log.size(); w++) begin
      logic [63:0] ed = '0;
      logic [15:0] em = '0;
      for (int j = 0; j < per; j++) begin
        int idx = w * per + j;
        if (idx < n) begin
          ed = ed | (64'(idx + 1) << (j * ew));
          em[j] = 1'b1;
        end
      end
      check($sformatf("%s[%0d] addr", tag, w), 64'(log[w].addr), 64'((base + w) % (1 << aw)));
      check($sformatf("%s[%0d] data", tag, w), log[w].data, ed);
      check($sformatf("%s[%0d] mask", tag, w), 64'(log[w].mask), 64'(em));
    end
  endtask

  initial begin
    pw.ctrl_valid = 0; pw.fm_base_i = '0; pw.gd_base_i = '0; pw.flush_i = 0;
    pw.data_i = '0; pw.data_i_valid = 0; pw.guard_i = '0; pw.guard_i_valid = 0;
    pw.fm_wr_gnt = 1'b1; pw.gd_wr_gnt = 1'b1;

    vecs[0] = '{fm_base: 'h010, gd_base: 'h00, nb: 16, ng: 0, fm_words: 2, fm_last_addr: 'h011,
                fm_last_mask: 'hFF, gd_words: 0, gd_last_addr: 0, gd_last_mask: 0};
    vecs[1] = '{fm_base: 'h020, gd_base: 'h05, nb: 11, ng: 5, fm_words: 2, fm_last_addr: 'h021,
                fm_last_mask: 'h07, gd_words: 2, gd_last_addr: 'h06, gd_last_mask: 'h1};
    vecs[2] = '{fm_base: 'h3FE, gd_base: 'h00, nb: 24, ng: 0, fm_words: 3, fm_last_addr: 'h000,
                fm_last_mask: 'hFF, gd_words: 0, gd_last_addr: 0, gd_last_mask: 0};
    vecs[3] = '{fm_base: 'h123, gd_base: 'h45, nb: 0, ng: 0, fm_words: 0, fm_last_addr: 0,
                fm_last_mask: 0, gd_words: 0, gd_last_addr: 0, gd_last_mask: 0};
    vecs[4] = '{fm_base: 'h100, gd_base: 'hFF, nb: 3, ng: 8, fm_words: 1, fm_last_addr: 'h100,
                fm_last_mask: 'h07, gd_words: 2, gd_last_addr: 'h00, gd_last_mask: 'hF};

    // Reset state
    repeat (2) tick();
    check("rst ctrl_ready", 64'(pw.ctrl_ready), 64'd1);
    check("rst done_o", 64'(pw.done_o), 64'd0);
    check("rst fm_wr_en", 64'(pw.fm_wr_en), 64'd0);
    check("rst gd_wr_en", 64'(pw.gd_wr_en), 64'd0);
    check("rst fm_buf_ready", 64'(pw.fm_buf_ready), 64'd0);
    check("rst fm_word_cnt", 64'(pw.fm_word_cnt_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table-driven jobs with grants tied high
    for (int i = 0; i < 5; i++) begin
      start_job(vecs[i].fm_base, vecs[i].gd_base);
      feed(vecs[i].nb, vecs[i].ng, 1, 1);
      finish_job();
      check($sformatf("vec%0d fm_word_cnt", i), 64'(pw.fm_word_cnt_o), 64'(vecs[i].fm_words));
      check($sformatf("vec%0d gd_word_cnt", i), 64'(pw.gd_word_cnt_o), 64'(vecs[i].gd_words));
      verify_side($sformatf("vec%0d fm", i), fm_log, vecs[i].fm_base, vecs[i].nb, FWB, 8, FM_AW);
      verify_side($sformatf("vec%0d gd", i), gd_log, vecs[i].gd_base, vecs[i].ng, GPW, 6, GD_AW);
      if (vecs[i].fm_words > 0 && fm_log.size() > 0) begin
        check($sformatf("vec%0d fm last addr", i), 64'(fm_log[fm_log.size()-1].addr), 64'(vecs[i].fm_last_addr));
        check($sformatf("vec%0d fm last mask", i), 64'(fm_log[fm_log.size()-1].mask), 64'(vecs[i].fm_last_mask));
      end
      if (vecs[i].gd_words > 0 && gd_log.size() > 0) begin
        check($sformatf("vec%0d gd last addr", i), 64'(gd_log[gd_log.size()-1].addr), 64'(vecs[i].gd_last_addr));
        check($sformatf("vec%0d gd last mask", i), 64'(gd_log[gd_log.size()-1].mask), 64'(vecs[i].gd_last_mask));
      end
    end

    // Back-pressure: grant withheld for 5 cycles while byte 9 waits
    pw.fm_wr_gnt = 1'b0;
    start_job('h040, 0);
    feed(8, 0, 1, 1);
    pw.data_i = 8'h09;
    pw.data_i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp fm_buf_ready", 64'(pw.fm_buf_ready), 64'd0);
      check("bp fm_wr_en", 64'(pw.fm_wr_en), 64'd1);
      check("bp fm_wr_addr", 64'(pw.fm_wr_addr), 64'h040);
      check("bp fm_wr_data", 64'(pw.fm_wr_data), 64'h0807060504030201);
      tick();
    end
    pw.fm_wr_gnt = 1'b1;
    @(negedge clk);
    check("bp ready on grant", 64'(pw.fm_buf_ready), 64'd1);
    tick();
    pw.data_i_valid = 1'b0;
    feed(7, 0, 10, 1);
    finish_job();
    check("bp fm_word_cnt", 64'(pw.fm_word_cnt_o), 64'd2);
    verify_side("bp fm", fm_log, 'h040, 16, FWB, 8, FM_AW);

    // Flush in the same cycle as the 8th byte
    start_job('h050, 0);
    feed(7, 0, 1, 1);
    pw.data_i = 8'h08;
    pw.data_i_valid = 1'b1;
    pw.flush_i = 1'b1;
    @(negedge clk);
    check("flush+byte ready", 64'(pw.fm_buf_ready), 64'd1);
    tick();
    pw.data_i_valid = 1'b0;
    pw.flush_i = 1'b0;
    wait_done();
    check("flush+byte fm_word_cnt", 64'(pw.fm_word_cnt_o), 64'd1);
    verify_side("flush+byte fm", fm_log, 'h050, 8, FWB, 8, FM_AW);

    // Empty job: one FLUSH cycle, then a single done pulse, no writes
    start_job('h070, 'h07);
    pw.flush_i = 1'b1;
    tick();
    pw.flush_i = 1'b0;
    @(negedge clk);
    check("empty done in FLUSH", 64'(pw.done_o), 64'd0);
    tick();
    @(negedge clk);
    check("empty done pulse", 64'(pw.done_o), 64'd1);
    check("empty ready in DONE", 64'(pw.fm_buf_ready), 64'd0);
    tick();
    @(negedge clk);
    check("empty done cleared", 64'(pw.done_o), 64'd0);
    check("empty ctrl_ready", 64'(pw.ctrl_ready), 64'd1);
    check("empty fm writes", 64'(fm_log.size()), 64'd0);
    check("empty gd writes", 64'(gd_log.size()), 64'd0);
    tick();

    // Reset mid-job with a pending FM word and partial guard lanes
    pw.fm_wr_gnt = 1'b0;
    start_job('h030, 'h10);
    feed(8, 2, 1, 1);
    @(negedge clk);
    check("pre-reset fm_wr_en", 64'(pw.fm_wr_en), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid-rst fm_wr_en", 64'(pw.fm_wr_en), 64'd0);
    check("mid-rst gd_wr_en", 64'(pw.gd_wr_en), 64'd0);
    check("mid-rst fm_wr_data", 64'(pw.fm_wr_data), 64'd0);
    check("mid-rst fm_wr_mask", 64'(pw.fm_wr_mask), 64'd0);
    check("mid-rst ctrl_ready", 64'(pw.ctrl_ready), 64'd1);
    check("mid-rst done_o", 64'(pw.done_o), 64'd0);
    check("mid-rst fm_word_cnt", 64'(pw.fm_word_cnt_o), 64'd0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    pw.fm_wr_gnt = 1'b1;
    tick();
    start_job('h060, 0);
    feed(8, 0, 1, 1);
    finish_job();
    check("post-rst fm_word_cnt", 64'(pw.fm_word_cnt_o), 64'd1);
    check("post-rst gd_word_cnt", 64'(pw.gd_word_cnt_o), 64'd0);
    verify_side("post-rst fm", fm_log, 'h060, 8, FWB, 8, FM_AW);
    verify_side("post-rst gd", gd_log, 0, 0, GPW, 6, GD_AW);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
